// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
package bcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int BIN_W = 14;
    localparam int BCD_W = 16;

    localparam logic [BIN_W-1:0] BIN_MAX = 14'd9999;
    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/grant and result handshake bundle for bcd_conv_arbiter.
// slave = arbiter side, master = requesters + result consumer.
interface bcd_conv_arbiter_if
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);

    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0][BIN_W-1:0] req_bin;
    logic [N_REQ-1:0]            gnt;
    logic                        out_valid;
    logic                        out_ready;
    logic [BCD_W-1:0]            out_bcd;
    logic [ID_W-1:0]             out_id;
    logic                        out_ovf;

    modport slave (
        input  req, req_bin, out_ready,
        output gnt, out_valid, out_bcd, out_id, out_ovf
    );

    modport master (
        output req, req_bin, out_ready,
        input  gnt, out_valid, out_bcd, out_id, out_ovf
    );

endinterface

// File: rtl/binary2bcd_div.sv
// Combinational 14-bit binary to 4-digit packed BCD by decimal division.
// Values above 9999 wrap modulo 10000 (thousands digit is taken mod 10).
module binary2bcd_div (
    input  logic [13:0] bin,
    output logic [15:0] bcd
);

    // Each digit is an independent divide/modulo of the operand.
    always_comb begin
        bcd[15:12] = 4'((bin / 14'd1000) % 14'd10);
        bcd[11:8]  = 4'((bin / 14'd100)  % 14'd10);
        bcd[7:4]   = 4'((bin / 14'd10)   % 14'd10);
        bcd[3:0]   = 4'(bin % 14'd10);
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that time-shares one binary2bcd_div among N_REQ
// requesters. IDLE grants and captures an operand, CONV registers the
// converted result, HOLD presents it until the consumer takes it.
// Optional feature macro: BCD_SAT_EN (clamp operands above 9999 to 9999
// and flag out_ovf); when undefined, operands wrap mod 10000 and out_ovf=0.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_conv_arbiter_if.slave   bus
);

    state_t           state, state_d;
    logic             take, done, ack;
    logic [ID_W-1:0]  rr_ptr, id_q, win, win_nxt;
    logic [N_REQ-1:0] win_oh;
    logic [BIN_W-1:0] op_q, conv_in;
    logic [BCD_W-1:0] conv_bcd;

    // First requester at or after p, wrapping; p itself when none is set.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] w;
        logic            hit;
        int              idx;
        w   = p;
        hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!hit && r[idx]) begin
                w   = ID_W'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    assign win     = rr_pick(bus.req, rr_ptr);
    assign win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
    assign win_nxt = (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;

`ifdef BCD_SAT_EN
    logic conv_ovf, ovf_q;

    assign conv_ovf = (op_q > BIN_MAX);
    assign conv_in  = conv_ovf ? BIN_MAX : op_q;

    // Overflow flag travels with the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf_q <= 1'b0;
        else if (done) ovf_q <= conv_ovf;
    end

    assign bus.out_ovf = ovf_q;
`else
    assign conv_in     = op_q;
    assign bus.out_ovf = 1'b0;
`endif

    binary2bcd_div u_conv (
        .bin (conv_in),
        .bcd (conv_bcd)
    );

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_d = state;
        take    = 1'b0;
        done    = 1'b0;
        ack     = 1'b0;
        case (state)
            IDLE: if (|bus.req) begin
                take    = 1'b1;
                state_d = CONV;
            end
            CONV: begin
                done    = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Grant/capture, result register and handshake flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            op_q          <= '0;
            id_q          <= '0;
            bus.gnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_bcd   <= '0;
            bus.out_id    <= '0;
        end else begin
            bus.gnt <= '0;
            if (take) begin
                op_q    <= bus.req_bin[win];
                id_q    <= win;
                bus.gnt <= win_oh;
                rr_ptr  <= win_nxt;
            end
            if (done) begin
                bus.out_bcd   <= conv_bcd;
                bus.out_id    <= id_q;
                bus.out_valid <= 1'b1;
            end
            if (ack) bus.out_valid <= 1'b0;
        end
    end

endmodule
